// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-port round-robin arbiter and sequencer in front of the shared 4-op ALU.
// One transaction is in flight at a time:
//   accept -> ISSUE (ALU samples operands) -> CAPTURE (latch ALU outputs)
//   -> RESP (hold the response until the owning port takes it).
// Optional feature macro: ALU_ARBITER_ILLEGAL_OP_EN
//   When defined, ops with op[3:2] != 2'b00 bypass the ALU and are answered
//   directly with result 0 and status 4'b1000.

module alu_arbiter #(
   parameter int N = 4,
   parameter int M = 8,
   parameter int K = 8
) (
   input  logic          i_clk,
   input  logic          i_reset,

   input  logic          i_req_valid_0,
   output logic          o_req_ready_0,
   input  logic [N-1:0]  i_op_0,
   input  logic [M-1:0]  i_arg_A_0,
   input  logic [M-1:0]  i_arg_B_0,

   input  logic          i_req_valid_1,
   output logic          o_req_ready_1,
   input  logic [N-1:0]  i_op_1,
   input  logic [M-1:0]  i_arg_A_1,
   input  logic [M-1:0]  i_arg_B_1,

   output logic          o_rsp_valid_0,
   input  logic          i_rsp_ready_0,
   output logic          o_rsp_valid_1,
   input  logic          i_rsp_ready_1,

   output logic [K-1:0]  o_result,
   output logic [3:0]    o_status,

   output logic [N-1:0]  o_alu_op,
   output logic [M-1:0]  o_alu_arg_A,
   output logic [M-1:0]  o_alu_arg_B,
   input  logic [K-1:0]  i_alu_result,
   input  logic [3:0]    i_alu_status,

   output logic          o_busy,
   output logic [7:0]    o_done_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t        state;
   logic          last_grant;
   logic          owner;

   logic          grant_0;
   logic          grant_1;
   logic          accept;
   logic [N-1:0]  sel_op;
   logic [M-1:0]  sel_arg_A;
   logic [M-1:0]  sel_arg_B;
   logic          sel_illegal;
   logic          owner_rsp_ready;

   // Round-robin grant: a lone requester always wins; on a tie the port
   // that did not win last time is chosen. Ready only exists in IDLE.
   always_comb begin
      grant_0         = i_req_valid_0 & (~i_req_valid_1 | last_grant);
      grant_1         = i_req_valid_1 & (~i_req_valid_0 | ~last_grant);
      o_req_ready_0   = (state == IDLE) & grant_0;
      o_req_ready_1   = (state == IDLE) & grant_1;
      accept          = o_req_ready_0 | o_req_ready_1;
      sel_op          = o_req_ready_1 ? i_op_1    : i_op_0;
      sel_arg_A       = o_req_ready_1 ? i_arg_A_1 : i_arg_A_0;
      sel_arg_B       = o_req_ready_1 ? i_arg_B_1 : i_arg_B_0;
      owner_rsp_ready = owner ? i_rsp_ready_1 : i_rsp_ready_0;
   end

   // Decide whether the selected op is answered locally instead of by the ALU.
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
   always_comb begin
      sel_illegal = (sel_op[3:2] != 2'b00);
   end
`else
   always_comb begin
      sel_illegal = 1'b0;
   end
`endif

   // Operand registers feed the ALU directly; they only load on an accepted
   // legal request, so the ALU never sees the request ports combinationally.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_alu_op    <= '0;
         o_alu_arg_A <= '0;
         o_alu_arg_B <= '0;
      end else if (accept && !sel_illegal) begin
         o_alu_op    <= sel_op;
         o_alu_arg_A <= sel_arg_A;
         o_alu_arg_B <= sel_arg_B;
      end
   end

   // Sequencer FSM with registered response, busy and completion outputs.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         owner         <= 1'b0;
         o_rsp_valid_0 <= 1'b0;
         o_rsp_valid_1 <= 1'b0;
         o_result      <= '0;
         o_status      <= '0;
         o_busy        <= 1'b0;
         o_done_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner      <= o_req_ready_1;
                  last_grant <= o_req_ready_1;
                  o_busy     <= 1'b1;
                  if (sel_illegal) begin
                     state         <= RESP;
                     o_result      <= '0;
                     o_status      <= 4'b1000;
                     o_rsp_valid_0 <= o_req_ready_0;
                     o_rsp_valid_1 <= o_req_ready_1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               state         <= RESP;
               o_result      <= i_alu_result;
               o_status      <= i_alu_status;
               o_rsp_valid_0 <= ~owner;
               o_rsp_valid_1 <= owner;
            end
            RESP: begin
               if (owner_rsp_ready) begin
                  state         <= IDLE;
                  o_rsp_valid_0 <= 1'b0;
                  o_rsp_valid_1 <= 1'b0;
                  o_busy        <= 1'b0;
                  o_done_cnt    <= o_done_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A one-stage registered ALU stand-in
// sits on the ALU side; a transaction-level model (grant history, expected
// ALU operands, completion count) predicts every response.

module tb_alu_arbiter;

   localparam int N = 4;
   localparam int M = 8;
   localparam int K = 8;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_req_valid_0 = 1'b0, i_req_valid_1 = 1'b0;
   logic          o_req_ready_0, o_req_ready_1;
   logic [N-1:0]  i_op_0 = '0, i_op_1 = '0;
   logic [M-1:0]  i_arg_A_0 = '0, i_arg_B_0 = '0, i_arg_A_1 = '0, i_arg_B_1 = '0;
   logic          o_rsp_valid_0, o_rsp_valid_1;
   logic          i_rsp_ready_0 = 1'b0, i_rsp_ready_1 = 1'b0;
   logic [K-1:0]  o_result;
   logic [3:0]    o_status;
   logic [N-1:0]  o_alu_op;
   logic [M-1:0]  o_alu_arg_A, o_alu_arg_B;
   logic [K-1:0]  alu_result = '0;
   logic [3:0]    alu_status = '0;
   logic          o_busy;
   logic [7:0]    o_done_cnt;

   int tests = 0;
   int fails = 0;

   int         m_last_grant;
   int         m_done;
   logic [3:0] m_alu_op;
   logic [7:0] m_alu_a, m_alu_b;

   alu_arbiter #(.N(N), .M(M), .K(K)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_req_valid_0(i_req_valid_0), .o_req_ready_0(o_req_ready_0),
      .i_op_0(i_op_0), .i_arg_A_0(i_arg_A_0), .i_arg_B_0(i_arg_B_0),
      .i_req_valid_1(i_req_valid_1), .o_req_ready_1(o_req_ready_1),
      .i_op_1(i_op_1), .i_arg_A_1(i_arg_A_1), .i_arg_B_1(i_arg_B_1),
      .o_rsp_valid_0(o_rsp_valid_0), .i_rsp_ready_0(i_rsp_ready_0),
      .o_rsp_valid_1(o_rsp_valid_1), .i_rsp_ready_1(i_rsp_ready_1),
      .o_result(o_result), .o_status(o_status),
      .o_alu_op(o_alu_op), .o_alu_arg_A(o_alu_arg_A), .o_alu_arg_B(o_alu_arg_B),
      .i_alu_result(alu_result), .i_alu_status(alu_status),
      .o_busy(o_busy), .o_done_cnt(o_done_cnt)
   );

   always #5 i_clk = ~i_clk;

   // ALU stand-in arithmetic: returns {status, result}.
   function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] r9;
      logic [3:0] st;
      case (op[1:0])
         2'd0:    r9 = {1'b0, a} + {1'b0, b};
         2'd1:    r9 = {1'b0, a} - {1'b0, b};
         2'd2:    r9 = {1'b0, a & b};
         default: r9 = {1'b0, a ^ b};
      endcase
      st = {op[3] & op[2], (r9[7:0] == 8'd0), r9[8], r9[7]};
      return {st, r9[7:0]};
   endfunction

   // Registered ALU: operands sampled at a rising edge appear after it.
   always @(posedge i_clk) begin
      {alu_status, alu_result} <= alu_fn(o_alu_op, o_alu_arg_A, o_alu_arg_B);
   end

   task automatic do_reset();
      i_req_valid_0 = 1'b0;
      i_req_valid_1 = 1'b0;
      i_rsp_ready_0 = 1'b0;
      i_rsp_ready_1 = 1'b0;
      @(posedge i_clk); #2;
      i_reset = 1'b0;
      repeat (2) @(posedge i_clk);
      #2;
      i_reset = 1'b1;
      m_last_grant = 1;
      m_done = 0;
      m_alu_op = '0;
      m_alu_a = '0;
      m_alu_b = '0;
      @(posedge i_clk); #1;
   endtask

   // One full transaction from request to handshake, checked against the model.
   task automatic do_txn(input logic v0, input logic v1,
                         input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         input int stall, output int owner);
      int         lat;
      logic [1:0] exp_ready;
      logic [1:0] exp_rsp;
      logic [3:0] eop;
      logic [7:0] ea, eb, eres;
      logic [3:0] est;
      logic       illegal;
      i_req_valid_0 = v0; i_op_0 = op0; i_arg_A_0 = a0; i_arg_B_0 = b0;
      i_req_valid_1 = v1; i_op_1 = op1; i_arg_A_1 = a1; i_arg_B_1 = b1;
      i_rsp_ready_0 = 1'b0;
      i_rsp_ready_1 = 1'b0;
      if (v0 && v1) owner = (m_last_grant == 0) ? 1 : 0;
      else          owner = v1 ? 1 : 0;
      exp_ready = (owner == 1) ? 2'b10 : 2'b01;
      eop = (owner == 1) ? op1 : op0;
      ea  = (owner == 1) ? a1  : a0;
      eb  = (owner == 1) ? b1  : b0;
      illegal = 1'b0;
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
      illegal = (eop[3:2] != 2'b00);
`endif
      if (illegal) begin
         lat = 1; eres = 8'h00; est = 4'b1000;
      end else begin
         lat = 3; {est, eres} = alu_fn(eop, ea, eb);
         m_alu_op = eop; m_alu_a = ea; m_alu_b = eb;
      end
      @(negedge i_clk);
      tests++;
      if ({o_req_ready_1, o_req_ready_0} !== exp_ready) begin
         fails++;
         $display("[TB] FAIL grant: ready={1,0}=%b expected %b", {o_req_ready_1, o_req_ready_0}, exp_ready);
      end
      @(posedge i_clk); #1;
      m_last_grant = owner;
      i_op_0 = 4'($urandom); i_arg_A_0 = 8'($urandom); i_arg_B_0 = 8'($urandom);
      i_op_1 = 4'($urandom); i_arg_A_1 = 8'($urandom); i_arg_B_1 = 8'($urandom);
      exp_rsp = (owner == 1) ? 2'b10 : 2'b01;
      for (int k = 1; k <= lat; k++) begin
         @(negedge i_clk);
         tests++;
         if ({o_rsp_valid_1, o_rsp_valid_0, o_req_ready_1, o_req_ready_0, o_busy} !==
             {((k == lat) ? exp_rsp : 2'b00), 2'b00, 1'b1}) begin
            fails++;
            $display("[TB] FAIL sequence k=%0d: rsp=%b ready=%b busy=%b expected rsp=%b ready=00 busy=1", k,
                     {o_rsp_valid_1, o_rsp_valid_0}, {o_req_ready_1, o_req_ready_0}, o_busy,
                     ((k == lat) ? exp_rsp : 2'b00));
         end
         if (k == 1) begin
            tests++;
            if ({o_alu_op, o_alu_arg_A, o_alu_arg_B} !== {m_alu_op, m_alu_a, m_alu_b}) begin
               fails++;
               $display("[TB] FAIL alu_operands: got %h/%h/%h expected %h/%h/%h", o_alu_op, o_alu_arg_A,
                        o_alu_arg_B, m_alu_op, m_alu_a, m_alu_b);
            end
         end
         if (k == lat) begin
            tests++;
            if ({o_status, o_result} !== {est, eres}) begin
               fails++;
               $display("[TB] FAIL response: status/result %b/%h expected %b/%h", o_status, o_result, est, eres);
            end
         end else begin
            @(posedge i_clk); #1;
         end
      end
      for (int s = 0; s < stall; s++) begin
         if (owner == 1) i_rsp_ready_0 = 1'b1; else i_rsp_ready_1 = 1'b1;
         @(posedge i_clk); #1;
         @(negedge i_clk);
         tests++;
         if ({o_rsp_valid_1, o_rsp_valid_0, o_req_ready_1, o_req_ready_0, o_status, o_result} !==
             {exp_rsp, 2'b00, est, eres}) begin
            fails++;
            $display("[TB] FAIL stall s=%0d: rsp=%b ready=%b st/res=%b/%h expected rsp=%b ready=00 st/res=%b/%h", s,
                     {o_rsp_valid_1, o_rsp_valid_0}, {o_req_ready_1, o_req_ready_0}, o_status, o_result,
                     exp_rsp, est, eres);
         end
      end
      if (owner == 1) i_rsp_ready_1 = 1'b1; else i_rsp_ready_0 = 1'b1;
      @(posedge i_clk); #1;
      m_done = (m_done + 1) % 256;
      i_rsp_ready_0 = 1'b0;
      i_rsp_ready_1 = 1'b0;
      i_req_valid_0 = 1'b0;
      i_req_valid_1 = 1'b0;
      tests++;
      if ({o_done_cnt, o_rsp_valid_1, o_rsp_valid_0, o_busy} !== {8'(m_done), 3'b000}) begin
         fails++;
         $display("[TB] FAIL handshake: done=%0d rsp=%b busy=%b expected done=%0d rsp=00 busy=0", o_done_cnt,
                  {o_rsp_valid_1, o_rsp_valid_0}, o_busy, m_done);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge i_clk);
      tests++;
      if ({o_req_ready_0, o_req_ready_1, o_rsp_valid_0, o_rsp_valid_1, o_result, o_status, o_alu_op,
           o_alu_arg_A, o_alu_arg_B, o_busy, o_done_cnt} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_state: result=%h status=%b alu=%h/%h/%h busy=%b done=%0d expected all zero",
                  o_result, o_status, o_alu_op, o_alu_arg_A, o_alu_arg_B, o_busy, o_done_cnt);
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_basic();
      int owner;
      do_txn(1'b1, 1'b0, 4'b0001, 8'h03, 8'h04, 4'b0000, 8'h00, 8'h00, 0, owner);
      tests++;
      if (o_done_cnt !== 8'd1) begin
         fails++;
         $display("[TB] FAIL basic_done: done=%0d expected 1", o_done_cnt);
      end
   endtask

   task automatic test_round_robin();
      int owner;
      int pattern[4] = '{0, 1, 0, 1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         do_txn(1'b1, 1'b1, 4'($urandom), 8'($urandom), 8'($urandom),
                4'($urandom), 8'($urandom), 8'($urandom), 0, owner);
         tests++;
         if (owner != pattern[i]) begin
            fails++;
            $display("[TB] FAIL rr_order i=%0d: owner=%0d expected %0d", i, owner, pattern[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int owner;
      do_txn(1'b0, 1'b1, 4'b0000, 8'h00, 8'h00, 4'b0010, 8'h5a, 8'h3c, 5, owner);
      do_txn(1'b1, 1'b0, 4'b0011, 8'hf0, 8'h0f, 4'b0000, 8'h00, 8'h00, 0, owner);
   endtask

   task automatic test_reset_capture();
      int owner;
      do_reset();
      i_req_valid_0 = 1'b1; i_op_0 = 4'b0000; i_arg_A_0 = 8'h11; i_arg_B_0 = 8'h22;
      @(negedge i_clk);
      tests++;
      if (o_req_ready_0 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL rc_accept: ready0=%b expected 1", o_req_ready_0);
      end
      @(posedge i_clk); #1;
      i_req_valid_0 = 1'b0;
      i_rsp_ready_0 = 1'b1;
      @(posedge i_clk); #3;
      i_reset = 1'b0;
      #1;
      tests++;
      if ({o_req_ready_0, o_req_ready_1, o_rsp_valid_0, o_rsp_valid_1, o_result, o_status, o_alu_op,
           o_alu_arg_A, o_alu_arg_B, o_busy, o_done_cnt} !== '0) begin
         fails++;
         $display("[TB] FAIL rc_async_clear: alu=%h/%h/%h busy=%b done=%0d expected all zero",
                  o_alu_op, o_alu_arg_A, o_alu_arg_B, o_busy, o_done_cnt);
      end
      @(posedge i_clk); #2;
      i_reset = 1'b1;
      m_last_grant = 1; m_done = 0; m_alu_op = '0; m_alu_a = '0; m_alu_b = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         tests++;
         if ({o_rsp_valid_1, o_rsp_valid_0, o_busy, o_done_cnt} !== '0) begin
            fails++;
            $display("[TB] FAIL rc_no_response c=%0d: rsp=%b busy=%b done=%0d expected 0", c,
                     {o_rsp_valid_1, o_rsp_valid_0}, o_busy, o_done_cnt);
         end
      end
      i_rsp_ready_0 = 1'b0;
      @(posedge i_clk); #1;
      do_txn(1'b1, 1'b1, 4'b0000, 8'h01, 8'h02, 4'b0001, 8'h09, 8'h03, 0, owner);
      tests++;
      if (owner != 0) begin
         fails++;
         $display("[TB] FAIL rc_first_grant: owner=%0d expected 0", owner);
      end
   endtask

   task automatic test_random();
      int owner;
      logic v0, v1;
      for (int i = 0; i < 40; i++) begin
         v0 = 1'($urandom);
         v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         do_txn(v0, v1, 4'($urandom), 8'($urandom), 8'($urandom),
                4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(3, 0)), owner);
      end
   endtask

   task automatic test_back_to_back();
      int owner;
      logic [7:0] start;
      start = o_done_cnt;
      for (int i = 0; i < 256; i++) begin
         do_txn(1'b1, 1'b1, 4'($urandom), 8'($urandom), 8'($urandom),
                4'($urandom), 8'($urandom), 8'($urandom), 0, owner);
      end
      tests++;
      if (o_done_cnt !== start) begin
         fails++;
         $display("[TB] FAIL wrap: done=%0d expected %0d after 256 completions", o_done_cnt, start);
      end
   endtask

`ifdef ALU_ARBITER_ILLEGAL_OP_EN
   task automatic test_illegal_op();
      int owner;
      do_txn(1'b0, 1'b1, 4'b0000, 8'h00, 8'h00, 4'b0100, 8'h77, 8'h88, 0, owner);
      do_txn(1'b1, 1'b0, 4'b1110, 8'h12, 8'h34, 4'b0000, 8'h00, 8'h00, 2, owner);
   endtask
`endif

   initial begin
      m_last_grant = 1; m_done = 0; m_alu_op = '0; m_alu_a = '0; m_alu_b = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_capture();
      test_round_robin();
      test_random();
`ifdef ALU_ARBITER_ILLEGAL_OP_EN
      test_illegal_op();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
